// File: rtl/mem_rs.sv
// In-order memory-op reservation queue: holds dispatched loads/stores, snoops the
// CDB for missing operands and issues the head to the memory controller when ready.
module mem_rs #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [6:0]              disp_opcode,
  input  logic [4:0]              disp_rd,
  input  logic [31:0]             disp_imm,
  input  logic [TAG_W-1:0]        disp_waw_id,
  input  logic [31:0]             disp_a,
  input  logic [31:0]             disp_b,
  input  logic                    disp_a_vld,
  input  logic                    disp_b_vld,
  input  logic [TAG_W-1:0]        disp_a_tag,
  input  logic [TAG_W-1:0]        disp_b_tag,
  input  logic                    cdb_vld,
  input  logic [31:0]             cdb_data,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic                    pull,
  output logic [6:0]              opcode_o,
  output logic [4:0]              rd_o,
  output logic [31:0]             imm_o,
  output logic [31:0]             a_o,
  output logic [31:0]             b_o,
  output logic [TAG_W-1:0]        waw_id_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LB = 7'd11;
  localparam logic [6:0] OP_SB = 7'd16;
  localparam logic [6:0] OP_SW = 7'd18;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [TAG_W-1:0] waw_id;
    logic [31:0]      a;
    logic             a_vld;
    logic [TAG_W-1:0] a_tag;
    logic [31:0]      b;
    logic             b_vld;
    logic [TAG_W-1:0] b_tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;

  entry_t hd_c;
  entry_t new_ent_c;
  logic   op_ok_c;
  logic   enq_c;
  logic   issue_c;
  logic   a_hit_c;
  logic   b_hit_c;
  logic   is_store_c;
  logic   head_rdy_c;

  // Dispatch acceptance and the incoming entry, with same-cycle CDB capture.
  always_comb begin
    disp_ready = reset && (cnt_q < CNT_W'(DEPTH)) && !flush;
    op_ok_c    = (disp_opcode >= OP_LB) && (disp_opcode <= OP_SW);
    enq_c      = disp_valid && disp_ready && op_ok_c;

    new_ent_c        = '0;
    new_ent_c.opcode = disp_opcode;
    new_ent_c.rd     = disp_rd;
    new_ent_c.imm    = disp_imm;
    new_ent_c.waw_id = disp_waw_id;
    new_ent_c.a_tag  = disp_a_tag;
    new_ent_c.b_tag  = disp_b_tag;
    new_ent_c.a_vld  = disp_a_vld || (cdb_vld && (disp_a_tag == cdb_tag));
    new_ent_c.b_vld  = disp_b_vld || (cdb_vld && (disp_b_tag == cdb_tag));
    new_ent_c.a      = disp_a_vld ? disp_a : cdb_data;
    new_ent_c.b      = disp_b_vld ? disp_b : cdb_data;
  end

  // Head readiness and issue; operands bypass from the CDB so capture and issue share a cycle.
  always_comb begin
    hd_c       = ent_q[head_q];
    a_hit_c    = cdb_vld && !hd_c.a_vld && (hd_c.a_tag == cdb_tag);
    b_hit_c    = cdb_vld && !hd_c.b_vld && (hd_c.b_tag == cdb_tag);
    is_store_c = (hd_c.opcode >= OP_SB) && (hd_c.opcode <= OP_SW);
    head_rdy_c = (hd_c.a_vld || a_hit_c) && (!is_store_c || hd_c.b_vld || b_hit_c);
    issue_c    = reset && !flush && vld_q[head_q] && head_rdy_c && pull;

    opcode_o = issue_c ? hd_c.opcode : 7'd0;
    rd_o     = hd_c.rd;
    imm_o    = hd_c.imm;
    waw_id_o = hd_c.waw_id;
    a_o      = a_hit_c ? cdb_data : hd_c.a;
    b_o      = b_hit_c ? cdb_data : hd_c.b;
    count_o  = cnt_q;
  end

  // Queue control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (enq_c) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (issue_c) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      unique case ({enq_c, issue_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry payloads: CDB snoop on waiting operands, then the enqueue write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cdb_vld && !ent_q[i].a_vld && (ent_q[i].a_tag == cdb_tag)) begin
        ent_q[i].a     <= cdb_data;
        ent_q[i].a_vld <= 1'b1;
      end
      if (vld_q[i] && cdb_vld && !ent_q[i].b_vld && (ent_q[i].b_tag == cdb_tag)) begin
        ent_q[i].b     <= cdb_data;
        ent_q[i].b_vld <= 1'b1;
      end
    end
    if (enq_c) ent_q[tail_q] <= new_ent_c;
  end

endmodule

// File: doc/mem_rs.md
MEM_RS -- requirements
Module: mem_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 8: width of producer tags (waw ids).
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Ports: clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port flush (input, 1): discards all queued entries.
REQ-005 SHALL have port disp_valid (input, 1): dispatch offers a memory op this cycle.
REQ-006 SHALL have port disp_ready (output, 1): queue accepts a dispatch this cycle.
REQ-007 SHALL have port disp_opcode (input, 7): op code; LB=11, LH=12, LW=13, LBU=14, LHU=15, SB=16, SH=17, SW=18.
REQ-008 SHALL have port disp_rd (input, 5): destination register.
REQ-009 SHALL have port disp_imm (input, 32): offset.
REQ-010 SHALL have port disp_waw_id (input, TAG_W): issue id of this op.
REQ-011 SHALL have ports disp_a, disp_b (input, 32 each): base and store-data values.
REQ-012 SHALL have ports disp_a_vld, disp_b_vld (input, 1 each): operand value present.
REQ-013 SHALL have ports disp_a_tag, disp_b_tag (input, TAG_W each): producer tag when not present.
REQ-014 SHALL have port cdb_vld (input, 1): common data bus broadcast valid.
REQ-015 SHALL have port cdb_data (input, 32): broadcast result.
REQ-016 SHALL have port cdb_tag (input, TAG_W): broadcast producer id.
REQ-017 SHALL have port pull (input, 1): downstream memory controller can take an op this cycle.
REQ-018 SHALL have port opcode_o (output, 7): op to memory controller; 0 when nothing is issued.
REQ-019 SHALL have ports rd_o (output, 5), imm_o (output, 32), a_o (output, 32), b_o (output, 32), waw_id_o (output, TAG_W): fields of the issued op.
REQ-020 SHALL have port count_o (output, log2(DEPTH)+1): current occupancy.

Function
REQ-021 SHALL be a circular in-order FIFO with head/tail pointers that wrap modulo DEPTH; ops issue strictly in dispatch order.
REQ-022 SHALL drive disp_ready = (count_o < DEPTH) and not flush.
REQ-023 SHALL enqueue an entry when disp_valid and disp_ready and disp_opcode is in 11..18; otherwise no entry is written and the op is silently dropped.
REQ-024 SHALL, on each clock when cdb_vld is high, capture cdb_data into every valid entry operand that is not yet valid and whose tag equals cdb_tag, and set that operand valid.
REQ-025 SHALL apply the same capture to an entry being enqueued in the same cycle, so a missing operand whose tag equals cdb_tag is stored as valid with cdb_data.
REQ-026 SHALL treat the head as ready when a is valid and, for store opcodes 16..18 only, b is also valid; a load ignores b.
REQ-027 SHALL assert issue = head valid, head ready and pull, combinationally; opcode_o = head opcode when issue is asserted, else 0.
REQ-028 SHALL drive rd_o, imm_o, a_o, b_o and waw_id_o from the head at all times; they are don't-care when opcode_o = 0.
REQ-029 SHALL drive a_o/b_o from cdb_data when the head operand is being captured that same cycle (bypass), so a head made ready by the CDB issues in the same cycle.
REQ-030 SHALL pop the head on the rising edge following a cycle in which issue is asserted.
REQ-031 SHALL support a simultaneous enqueue and pop: count_o stays unchanged and both pointers advance.
REQ-032 SHALL, with flush high, suppress issue (opcode_o = 0) and set head = tail = 0, count_o = 0 and all entry-valid bits to 0 at the next edge; a dispatch offered in that cycle is dropped.
REQ-033 SHALL leave the queue state unchanged when it is empty and pull is high; opcode_o = 0.

Reset
REQ-034 SHALL, while reset = 0 and independent of clk, clear head, tail, count_o and all valid bits; opcode_o = 0 and disp_ready = 0.
REQ-035 SHALL resume normal operation on the first rising clk edge after reset returns to 1; entry payload registers need no reset.

Verification
REQ-036 Bench SHALL cover: dispatch LW with rd=5, a=0x100 valid, imm=4, pull=1 -> next cycle opcode_o=13, a_o=0x100, imm_o=4, rd_o=5; queue empty after the following edge.
REQ-037 Bench SHALL cover: SW with b_vld=0, b_tag=0x22, then cdb_vld with tag 0x22 and data 0xDEADBEEF -> opcode_o=18 with b_o=0xDEADBEEF in the broadcast cycle.
REQ-038 Bench SHALL cover: 4 dispatches with pull=0 -> count_o=4 and disp_ready=0; a 5th is refused; pull=1 then issues the ops in dispatch order over 4 cycles.
REQ-039 Bench SHALL cover: a head load waiting on tag 0x10 with a ready store behind it -> no issue until tag 0x10 is broadcast, then the load issues before the store.
REQ-040 Bench SHALL cover: 3 entries queued and flush pulsed together with disp_valid -> count_o=0 and opcode_o=0 on the next cycle, and the dispatched op is absent.
REQ-041 Bench SHALL cover: reset driven low mid-stream with 2 entries queued -> count_o=0 and opcode_o=0 immediately, without waiting for a clk edge.
